led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
- Multi-channel LED pattern generator, next generation of the single-LED blinker.
- One shared prescaler produces a timebase tick.
- Each of NumCh channels independently runs OFF / ON / BLINK (programmable period and duty) / BURST (N blinks then stop) from its own config.
- Sits between the register bank (config inputs) and board LED pins.

Parameters:
- NumCh, 4, number of independent LED channels
- CounterWidth, 16, width of per-channel period/duty counter (in ticks)
- PrescaleWidth, 8, width of shared prescaler
- BurstWidth, 8, width of burst blink count

Ports:
- clk_i  in  1  rising-edge clock
- rst_i  in  1  synchronous reset, active high
- en_i  in  1  global enable; low freezes prescaler and all channel counters
- prescale_i  in  PrescaleWidth  tick period minus one, in clk cycles
- mode_i  in  NumCh x 2  per-channel mode (mode_e)
- period_i  in  NumCh x CounterWidth  per-channel period minus one, in ticks
- duty_i  in  NumCh x CounterWidth  per-channel high time, in ticks
- burst_i  in  NumCh x BurstWidth  blinks per burst
- start_i  in  NumCh  per-channel burst start pulse
- led_o  out  NumCh  registered LED outputs
- busy_o  out  NumCh  channel running a burst
- done_o  out  NumCh  one-cycle pulse at burst completion

Behaviour:
- Reset (rst_i sampled high at clk_i edge): led_o=0, busy_o=0, done_o=0; prescaler, channel counters and burst counters=0; shadow period/duty=0; all channels IDLE.
- Prescaler: increments each cycle while en_i=1. When value==prescale_i: tick=1 for that cycle and prescaler clears to 0. Tick period is prescale_i+1 cycles; prescale_i=0 gives a tick every cycle.
- Channel counter cnt: on tick, cnt==shadow_period -> cnt=0 (wrap, period boundary), else cnt+1. Runs only in BLINK, or in BURST while busy.
- Shadow period/duty load from period_i/duty_i at each wrap and on entry to BLINK or burst start. Mid-period config changes never glitch the output.
- Output is registered, one-cycle latency from its decision. led_o is high when cnt < shadow_duty. Boundary cases:
  - duty=0: constant low.
  - duty > period: constant high.
  - period=0: 1-tick period.
- OFF: led_o=0 and cnt=0, effective next cycle.
- ON: led_o=1, effective next cycle.
- BLINK: continuous pattern. Entering BLINK restarts at cnt=0 with led high (if duty>0).
- BURST, state machine IDLE -> RUN -> IDLE:
  - IDLE: led_o=0.
  - start_i with burst_i>0: go RUN, busy_o=1 next cycle, cnt=0, blink counter=0.
  - Each wrap in RUN increments blink counter. When it reaches burst_i (sampled at start), next cycle: IDLE, busy_o=0, done_o=1 for one cycle, led_o=0.
  - start_i with burst_i=0: no effect, no done.
  - start_i while RUN: ignored. start_i in non-BURST modes: ignored.
- Mode change while RUN: abort to the new mode immediately. busy_o drops, no done_o.
- en_i=0: prescaler, cnt and burst state hold; led_o holds last value. OFF/ON still take effect.
- Channels are fully independent. Simultaneous start on several channels is legal.

Optional Feature:
- LED_PATTERN_SYNC_EN defined: adds input sync_i (1 bit). sync_i=1 clears the prescaler and every channel cnt to 0 in the same cycle, and reloads shadows. This phase-aligns all channels; burst counters are unaffected. sync_i has priority over tick.
- Not defined: no sync_i port; channel phases are set only by reset and mode entry.

Decomposition:
- Package led_pattern_pkg:
  - mode_e enum, 2 bits: MODE_OFF=0, MODE_ON=1, MODE_BLINK=2, MODE_BURST=3.
  - burst_state_e: IDLE, RUN.
  - Default width constants.
- Sub-module led_channel: one channel's cnt, shadows, burst FSM and output register. Instantiated NumCh times in a generate loop.
- Top level holds the prescaler and the optional sync.

Test Plan:
- Reset, then NumCh=4, prescale=0, ch0 BLINK period=3 duty=2 -> ch0 led_o repeats 1,1,0,0; other channels in OFF stay 0.
- prescale=9, ch1 BLINK period=1 duty=1 -> ch1 led_o toggles every 10 cycles.
- ch2 BURST burst=3 period=3 duty=1, start pulse -> busy 1 cycle later, exactly 3 high pulses, done_o one cycle, busy 0, led 0; second start during RUN ignored.
- ch0 BLINK duty=0 -> led 0 always; duty=5 with period=3 -> led 1 always. Change period mid-cycle -> takes effect only after wrap.
- en_i low for 20 cycles mid-pattern -> led_o and phase frozen, resume exactly where stopped. rst_i mid-burst -> all outputs 0 next cycle, no done.
- With LED_PATTERN_SYNC_EN: two channels at different phases, pulse sync_i -> both show cnt=0 with matching led_o sequences afterward.

Source files
------------

// File: rtl/led_pattern_gen_pkg.sv
// led_pattern_pkg: shared mode/state types and default widths for the LED pattern generator
package led_pattern_pkg;
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } burst_state_e;
  localparam int DefNumCh = 4;
  localparam int DefCounterWidth = 16;
  localparam int DefPrescaleWidth = 8;
  localparam int DefBurstWidth = 8;
endpackage

// File: rtl/led_channel.sv
// led_channel: one LED channel with period/duty counter, shadow config, burst FSM and output register
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int CounterWidth = DefCounterWidth,
  parameter int BurstWidth = DefBurstWidth
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    sync,
  input  mode_e                   mode,
  input  logic [CounterWidth-1:0] period,
  input  logic [CounterWidth-1:0] duty,
  input  logic [BurstWidth-1:0]   burst,
  input  logic                    start,
  output logic                    led,
  output logic                    busy,
  output logic                    done
);
  mode_e mode_q;
  burst_state_e state, state_n;
  logic [CounterWidth-1:0] cnt, cnt_n, sper, sper_n, sduty, sduty_n;
  logic [BurstWidth-1:0] bcnt, blen;
  logic enter_blink, launch, run, active, wrap, last, load, led_n;
  // The output is decided from next-state counter and shadows so led always matches cnt.
  always_comb begin
    enter_blink = mode == MODE_BLINK && mode_q != MODE_BLINK;
    launch = mode == MODE_BURST && state == IDLE && start && burst != '0;
    run = mode == MODE_BURST && state == RUN;
    active = (mode == MODE_BLINK && !enter_blink) || run;
    wrap = active && !sync && tick && cnt == sper;
    last = run && wrap && bcnt + BurstWidth'(1) == blen;
    load = enter_blink || launch || wrap || (active && sync);
    cnt_n = (!active || sync || wrap) ? '0 : tick ? cnt + CounterWidth'(1) : cnt;
    sper_n = load ? period : sper;
    sduty_n = load ? duty : sduty;
    state_n = (launch || (run && !last)) ? RUN : IDLE;
    led_n = mode == MODE_ON || ((mode == MODE_BLINK || state_n == RUN) && cnt_n < sduty_n);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_OFF;
      state <= IDLE;
      cnt <= '0;
      sper <= '0;
      sduty <= '0;
      bcnt <= '0;
      blen <= '0;
      led <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      mode_q <= mode;
      state <= state_n;
      cnt <= cnt_n;
      sper <= sper_n;
      sduty <= sduty_n;
      bcnt <= launch ? '0 : (run && wrap) ? bcnt + BurstWidth'(1) : bcnt;
      blen <= launch ? burst : blen;
      led <= led_n;
      busy <= state_n == RUN;
      done <= last;
    end
  end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED pattern generator sharing one prescaler timebase.
// Define LED_PATTERN_SYNC_EN to add sync_i, which phase-aligns all running channels.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NumCh = DefNumCh,
  parameter int CounterWidth = DefCounterWidth,
  parameter int PrescaleWidth = DefPrescaleWidth,
  parameter int BurstWidth = DefBurstWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                en_i,
  input  logic [PrescaleWidth-1:0]            prescale_i,
  input  logic [NumCh-1:0][1:0]               mode_i,
  input  logic [NumCh-1:0][CounterWidth-1:0]  period_i,
  input  logic [NumCh-1:0][CounterWidth-1:0]  duty_i,
  input  logic [NumCh-1:0][BurstWidth-1:0]    burst_i,
  input  logic [NumCh-1:0]                    start_i,
`ifdef LED_PATTERN_SYNC_EN
  input  logic                                sync_i,
`endif
  output logic [NumCh-1:0]                    led_o,
  output logic [NumCh-1:0]                    busy_o,
  output logic [NumCh-1:0]                    done_o
);
  logic [PrescaleWidth-1:0] pre;
  logic sync, tick;
`ifdef LED_PATTERN_SYNC_EN
  assign sync = sync_i;
`else
  assign sync = 1'b0;
`endif
  assign tick = en_i && !sync && pre == prescale_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) pre <= '0;
    else if (sync || tick) pre <= '0;
    else if (en_i) pre <= pre + PrescaleWidth'(1);
  end
  genvar i;
  for (i = 0; i < NumCh; i++) begin : g_ch
    led_channel #(
      .CounterWidth(CounterWidth),
      .BurstWidth(BurstWidth)
    ) u_ch (
      .clk(clk_i),
      .rst(rst_i),
      .tick(tick),
      .sync(sync),
      .mode(mode_e'(mode_i[i])),
      .period(period_i[i]),
      .duty(duty_i[i]),
      .burst(burst_i[i]),
      .start(start_i[i]),
      .led(led_o[i]),
      .busy(busy_o[i]),
      .done(done_o[i])
    );
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed and randomized checks of led_pattern_gen against a tick-level reference model
module tb_led_pattern_gen;
  import led_pattern_pkg::*;
  localparam int N = 4, CW = 16, PW = 8, BW = 8;
  logic clk = 1'b0;
  logic rst, en, sync;
  logic [PW-1:0] prescale;
  logic [N-1:0][1:0] mode;
  logic [N-1:0][CW-1:0] period, duty;
  logic [N-1:0][BW-1:0] burst;
  logic [N-1:0] start, led, busy, done;
  int checks = 0, failures = 0;
  int m_pre;
  int m_pos[N], m_shp[N], m_shd[N], m_rem[N];
  bit m_run[N];
  logic [1:0] m_prev[N];
  logic [N-1:0] e_led, e_busy, e_done;
  int pulses, dones;
  logic prev_led;

  always #5 clk = ~clk;

  led_pattern_gen dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .prescale_i(prescale), .mode_i(mode),
    .period_i(period), .duty_i(duty), .burst_i(burst), .start_i(start),
`ifdef LED_PATTERN_SYNC_EN
    .sync_i(sync),
`endif
    .led_o(led), .busy_o(busy), .done_o(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A channel's period starts over at position 0 with freshly captured period/duty.
  task automatic restart(input int c);
    m_pos[c] = 0;
    m_shp[c] = int'(period[c]);
    m_shd[c] = int'(duty[c]);
  endtask

  task automatic advance(input int c, output bit wrapped);
    wrapped = m_pos[c] == m_shp[c];
    if (wrapped) restart(c);
    else m_pos[c]++;
  endtask

  task automatic step();
    bit tk, w;
    if (rst) begin
      m_pre = 0;
      for (int c = 0; c < N; c++) begin
        m_pos[c] = 0; m_shp[c] = 0; m_shd[c] = 0; m_rem[c] = 0; m_run[c] = 0; m_prev[c] = MODE_OFF;
      end
      e_led = '0; e_busy = '0; e_done = '0;
      return;
    end
    tk = en && !sync && m_pre == int'(prescale);
    if (sync || tk) m_pre = 0;
    else if (en) m_pre = (m_pre + 1) % 256;
    for (int c = 0; c < N; c++) begin
      e_done[c] = 1'b0;
      if (mode[c] == MODE_BLINK) begin
        m_run[c] = 0;
        if (m_prev[c] != MODE_BLINK || sync) restart(c);
        else if (tk) advance(c, w);
        e_led[c] = m_pos[c] < m_shd[c];
      end else if (mode[c] == MODE_BURST) begin
        if (!m_run[c]) begin
          if (start[c] && burst[c] != 0) begin
            m_run[c] = 1;
            m_rem[c] = int'(burst[c]);
            restart(c);
          end
        end else if (sync) restart(c);
        else if (tk) begin
          advance(c, w);
          if (w) begin
            m_rem[c]--;
            if (m_rem[c] == 0) begin
              m_run[c] = 0;
              e_done[c] = 1'b1;
            end
          end
        end
        e_led[c] = m_run[c] && m_pos[c] < m_shd[c];
      end else begin
        m_run[c] = 0;
        m_pos[c] = 0;
        e_led[c] = mode[c] == MODE_ON;
      end
      e_busy[c] = m_run[c];
      m_prev[c] = mode[c];
    end
  endtask

  task automatic cyc();
    step();
    @(posedge clk);
    #1;
    chk("led", led, e_led);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; sync = 1'b0; prescale = '0; start = '0;
    mode = '0; period = '0; duty = '0; burst = '0;
    repeat (2) cyc();
    chk("reset_led", led, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    // Basic blink, 4-tick period with 2 ticks high
    mode[0] = MODE_BLINK; period[0] = 3; duty[0] = 2;
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("blink_seq", led[0], (i % 4) < 2);
      chk("off_chan", led[3:1], 0);
    end
    // Slow timebase: one tick every 10 clocks
    prescale = 9; mode[1] = MODE_BLINK; period[1] = 1; duty[1] = 1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      chk("slow_blink", led[1], (((i + 1) / 10) % 2) == 0);
    end
    // Burst of three blinks, with a second start while running
    prescale = 0;
    mode[2] = MODE_BURST; period[2] = 3; duty[2] = 1; burst[2] = 3;
    pulses = 0; dones = 0; prev_led = 1'b0;
    for (int i = 0; i < 18; i++) begin
      start[2] = (i == 0 || i == 4);
      cyc();
      if (i == 0) chk("burst_busy_start", busy[2], 1);
      if (led[2] && !prev_led) pulses++;
      prev_led = led[2];
      dones += int'(done[2]);
    end
    start[2] = 1'b0;
    chk("burst_pulses", pulses, 3);
    chk("burst_done_count", dones, 1);
    chk("burst_busy_end", busy[2], 0);
    chk("burst_led_end", led[2], 0);
    // Zero start count does nothing
    burst[2] = 0; start[2] = 1'b1;
    cyc();
    start[2] = 1'b0;
    chk("burst_zero_busy", busy[2], 0);
    // Duty boundaries and a mid-period period change
    duty[0] = 0;
    repeat (4) cyc();
    for (int i = 0; i < 4; i++) begin cyc(); chk("duty_zero", led[0], 0); end
    duty[0] = 5;
    repeat (4) cyc();
    for (int i = 0; i < 4; i++) begin cyc(); chk("duty_over", led[0], 1); end
    duty[0] = 2;
    repeat (6) cyc();
    period[0] = 7;
    repeat (16) cyc();
    // Freeze with enable low
    en = 1'b0;
    repeat (20) cyc();
    en = 1'b1;
    repeat (12) cyc();
    // Reset in the middle of a burst
    burst[2] = 4; start[2] = 1'b1;
    cyc();
    start[2] = 1'b0;
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    chk("rst_mid_led", led, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    rst = 1'b0;
    repeat (6) cyc();
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0) begin
        prescale = PW'($urandom_range(2));
        for (int c = 0; c < N; c++) begin
          mode[c] = 2'($urandom_range(3));
          period[c] = CW'($urandom_range(4));
          duty[c] = CW'($urandom_range(6));
          burst[c] = BW'($urandom_range(3));
        end
      end
      if ($urandom_range(15) == 0) begin
        int c;
        c = int'($urandom_range(N - 1));
        period[c] = CW'($urandom_range(4));
        duty[c] = CW'($urandom_range(6));
        if ($urandom_range(3) == 0) mode[c] = 2'($urandom_range(3));
      end
      start = N'($urandom) & N'($urandom);
      en = $urandom_range(7) != 0;
`ifdef LED_PATTERN_SYNC_EN
      sync = $urandom_range(19) == 0;
`endif
      cyc();
    end
    start = '0; en = 1'b1; sync = 1'b0;
`ifdef LED_PATTERN_SYNC_EN
    // Two channels at different phases aligned by sync
    prescale = 0; mode = '0;
    cyc();
    mode[0] = MODE_BLINK; period[0] = 3; duty[0] = 2;
    period[3] = 3; duty[3] = 2;
    repeat (2) cyc();
    mode[3] = MODE_BLINK;
    cyc();
    for (int i = 0; i < 8; i++) begin
      sync = (i == 0);
      cyc();
      chk("sync_ch0", led[0], (i % 4) < 2);
      chk("sync_ch3", led[3], (i % 4) < 2);
    end
    sync = 1'b0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
